prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter INSTR_W, default 18, instruction word width: 2-bit type plus 16-bit immediate.
REQ-002 SHALL have parameter ADDR_W, default 16, program-memory address width.
REQ-003 SHALL have port i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_byte  input  8  incoming load-stream byte.
REQ-006 SHALL have port i_byteValid  input  1  i_byte holds a valid byte.
REQ-007 SHALL have port o_byteReady  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port o_memAddr  output  ADDR_W  program-memory write address.
REQ-009 SHALL have port o_memData  output  INSTR_W  program-memory write data.
REQ-010 SHALL have port o_memWrite  output  1  one-cycle program-memory write strobe.
REQ-011 SHALL have port o_cpuHold  output  1  holds the CPU instruction pointer at 0 while high.
REQ-012 SHALL have port o_done  output  1  load completed successfully.
REQ-013 SHALL have port o_error  output  1  load aborted on a malformed stream.
REQ-014 SHALL have port o_count  output  ADDR_W  number of words written so far.

Function
REQ-015 SHALL define the stream as LEN_HI, LEN_LO (word count N, big-endian), then N words of 3 bytes each (B0, B1, B2, big-endian, right-aligned to INSTR_W).
REQ-016 SHALL accept a byte only on a cycle where i_byteValid and o_byteReady are both high.
REQ-017 SHALL implement states S_LENHI, S_LENLO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR.
REQ-018 SHALL drive o_byteReady high in S_LENHI, S_LENLO, S_B0, S_B1, S_B2 and S_CSUM, and low in every other state.
REQ-019 SHALL enter S_ERR when the accepted B0 has any of bits [7:2] set; no write occurs for that word.
REQ-020 SHALL, after accepting B2, enter S_WRITE for exactly one cycle with o_memWrite=1, o_memAddr=o_count and o_memData equal to the assembled word.
REQ-021 SHALL hold o_memWrite at 0 in every state except S_WRITE.
REQ-022 SHALL increment o_count on the cycle after S_WRITE, then go to S_B0 if o_count<N, else to the end state.
REQ-023 SHALL go directly from S_LENLO to the end state when N=0, producing no writes.
REQ-024 SHALL ignore bytes presented while o_byteReady is low; such bytes are not consumed.
REQ-025 SHALL treat S_DONE and S_ERR as terminal and absorbing until i_reset.
REQ-026 SHALL drive o_cpuHold high in every state except S_DONE; S_ERR keeps the CPU held.
REQ-027 SHALL drive o_done high only in S_DONE and o_error high only in S_ERR.
REQ-028 SHALL guarantee that o_memAddr never wraps, since N is at most 65535 and the last address is at most 65534.

Reset
REQ-029 SHALL, on i_reset high at a clock edge, enter S_LENHI with o_count=0, N=0, checksum=0, o_memWrite=0, o_done=0, o_error=0, o_cpuHold=1, o_byteReady=1 on the next cycle.
REQ-030 SHALL give i_reset priority over any byte accepted or write issued in the same cycle; a reset mid-load aborts the load and leaves already-written memory untouched.

Configuration
REQ-031 SHALL, with PROG_LOADER_CHECKSUM_EN defined, keep a running XOR of every accepted B0/B1/B2 byte, use S_CSUM as the end state, and accept one trailing byte there: equal to the XOR -> S_DONE, otherwise -> S_ERR.
REQ-032 SHALL, without PROG_LOADER_CHECKSUM_EN, omit S_CSUM and the XOR register, and use S_DONE as the end state.

Verification
REQ-033 SHALL cover: reset, then stream 00 02 | 00 12 34 | 03 FF FF with valid held high -> writes (0, 0x01234) and (1, 0x3FFFF); then o_done=1, o_cpuHold=0, o_count=2.
REQ-034 SHALL cover: stream 00 00 -> no o_memWrite; o_done=1 two cycles after LEN_LO is accepted (checksum off), or after a trailing 00 byte (checksum on).
REQ-035 SHALL cover: stream 00 01 | 04 00 00 -> o_error=1, o_cpuHold=1, no write, o_byteReady=0 thereafter.
REQ-036 SHALL cover: i_byteValid toggled randomly during a 3-word load -> identical writes and addresses to the back-to-back case, and no byte is lost or duplicated.
REQ-037 SHALL cover: i_reset asserted in the cycle after the second B1 of a 4-word load -> S_LENHI, o_count=0; a fresh 00 01 | 00 00 07 stream then writes (0, 0x00007).
REQ-038 SHALL cover, with PROG_LOADER_CHECKSUM_EN: stream 00 01 | 01 02 03 + 00 -> S_DONE; the same stream with trailing byte 01 -> o_error=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader. It takes a big-endian word count
// followed by 3-byte instruction words and writes each word into program
// memory, holding the CPU at address 0 until the load finishes.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require one trailing
// XOR checksum byte after the last word.
module prog_loader #(
  parameter int INSTR_W = 18,
  parameter int ADDR_W  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [7:0]         i_byte,
  input  logic               i_byteValid,
  output logic               o_byteReady,
  output logic [ADDR_W-1:0]  o_memAddr,
  output logic [INSTR_W-1:0] o_memData,
  output logic               o_memWrite,
  output logic               o_cpuHold,
  output logic               o_done,
  output logic               o_error,
  output logic [ADDR_W-1:0]  o_count
);

  typedef enum logic [3:0] {
    S_LENHI,
    S_LENLO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    count_q, len_q;
  logic [ADDR_W-1:0]    count_inc, len_in;
  logic [7:0]           len_hi_q, b0_q, b1_q;
  logic [INSTR_W-1:0]   mem_data_q;
  logic                 byte_ready_q, mem_write_q, done_q, error_q, hold_q;
  logic                 accept, ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  assign accept    = i_byteValid && byte_ready_q;
  assign count_inc = count_q + CNT_ONE;
  assign len_in    = ADDR_W'({len_hi_q, i_byte});

  // Next-state decode: advance only on accepted bytes, except the write cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LENHI: if (accept) state_d = S_LENLO;
      S_LENLO: if (accept) state_d = (len_in == '0) ? S_END : S_B0;
      S_B0:    if (accept) state_d = (|i_byte[7:2]) ? S_ERR : S_B1;
      S_B1:    if (accept) state_d = S_B2;
      S_B2:    if (accept) state_d = S_WRITE;
      S_WRITE: state_d = (count_inc < len_q) ? S_B0 : S_END;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM:  if (accept) state_d = (i_byte == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Byte-ready level for the state being entered, so the output is registered.
  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      S_LENHI, S_LENLO, S_B0, S_B1, S_B2: ready_d = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM:  ready_d = 1'b1;
`endif
      default: ready_d = 1'b0;
    endcase
  end

  // Control state, word counter and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_LENHI;
      count_q      <= '0;
      len_q        <= '0;
      byte_ready_q <= 1'b1;
      mem_write_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      hold_q       <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= ready_d;
      mem_write_q  <= (state_d == S_WRITE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERR);
      hold_q       <= (state_d != S_DONE);
      if (accept && state_q == S_LENLO) len_q <= len_in;
      if (state_q == S_WRITE) count_q <= count_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (accept && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2))
        csum_q <= csum_q ^ i_byte;
`endif
    end
  end

  // Byte capture and word assembly; pure data, no reset needed.
  always_ff @(posedge i_clock) begin
    if (accept && state_q == S_LENHI) len_hi_q <= i_byte;
    if (accept && state_q == S_B0) b0_q <= i_byte;
    if (accept && state_q == S_B1) b1_q <= i_byte;
    if (accept && state_q == S_B2) mem_data_q <= INSTR_W'({b0_q, b1_q, i_byte});
  end

  assign o_byteReady = byte_ready_q;
  assign o_memAddr   = count_q;
  assign o_memData   = mem_data_q;
  assign o_memWrite  = mem_write_q;
  assign o_cpuHold   = hold_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams against a stream-level model of the loader.
module tb_prog_loader;

  localparam int INSTR_W = 18;
  localparam int ADDR_W  = 16;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic [7:0]         i_byte = 8'h00;
  logic               i_byteValid = 1'b0;
  logic               o_byteReady;
  logic [ADDR_W-1:0]  o_memAddr;
  logic [INSTR_W-1:0] o_memData;
  logic               o_memWrite;
  logic               o_cpuHold;
  logic               o_done;
  logic               o_error;
  logic [ADDR_W-1:0]  o_count;

  prog_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_byte(i_byte),
    .i_byteValid(i_byteValid), .o_byteReady(o_byteReady),
    .o_memAddr(o_memAddr), .o_memData(o_memData), .o_memWrite(o_memWrite),
    .o_cpuHold(o_cpuHold), .o_done(o_done), .o_error(o_error),
    .o_count(o_count)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [7:0]         stim[$];
  logic [ADDR_W-1:0]  exp_addr[$];
  logic [INSTR_W-1:0] exp_data[$];
  bit                 exp_done, exp_err;
  int                 exp_consumed, exp_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  // Stream-level model: parse the byte list into the writes and the outcome.
  task automatic build_model();
    int n, p;
    logic [7:0] b0, b1, b2, x;
    logic [23:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; exp_consumed = 0; exp_count = 0; x = 8'h00;
    n = {stim[0], stim[1]};
    p = 2;
    for (int i = 0; i < n; i++) begin
      b0 = stim[p];
      if (b0[7:2] != 6'd0) begin
        exp_err = 1; exp_consumed = p + 1;
        return;
      end
      b1 = stim[p+1]; b2 = stim[p+2]; p += 3;
      w = {b0, b1, b2};
      exp_addr.push_back(i[ADDR_W-1:0]);
      exp_data.push_back(w[INSTR_W-1:0]);
      x = x ^ b0 ^ b1 ^ b2;
      exp_count = i + 1;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_consumed = p + 1;
    if (stim[p] == x) exp_done = 1; else exp_err = 1;
`else
    exp_consumed = p;
    exp_done = 1;
`endif
  endtask

  function automatic logic [7:0] stream_xor();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    return x;
  endfunction

  // Present bytes in order; a byte advances only when valid and ready coincide.
  task automatic send(input int nmax, input bit rnd, output int got);
    int cyc = 0;
    bit acc;
    got = 0;
    while (got < nmax && cyc < 2000 && !o_error) begin
      @(negedge i_clock);
      i_byte = stim[got];
      i_byteValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = i_byteValid && o_byteReady;
      @(posedge i_clock);
      if (acc) got++;
      cyc++;
    end
    @(negedge i_clock);
    i_byteValid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_byteValid = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b0;
    chk("rst_count", o_count, 0);
    chk("rst_ready", o_byteReady, 1);
    chk("rst_write", o_memWrite, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_hold", o_cpuHold, 1);
  endtask

  task automatic finish_checks(input string nm, input int got);
    for (int k = 0; k < 20 && !(o_done || o_error); k++) @(negedge i_clock);
    chk({nm, "_consumed"}, got, exp_consumed);
    chk({nm, "_done"}, o_done, exp_done);
    chk({nm, "_error"}, o_error, exp_err);
    chk({nm, "_hold"}, o_cpuHold, !exp_done);
    chk({nm, "_count"}, o_count, exp_count);
    chk({nm, "_pending"}, exp_addr.size(), 0);
  endtask

  task automatic run(input string nm, input bit rnd);
    int got;
    build_model();
    send(stim.size(), rnd, got);
    finish_checks(nm, got);
  endtask

  // Every cycle: writes against the model queue, plus status consistency.
  always @(negedge i_clock) begin
    if (armed && !i_reset) begin
      if (o_memWrite) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", o_memWrite, 0);
        end else begin
          chk("wr_addr", o_memAddr, exp_addr[0]);
          chk("wr_data", o_memData, exp_data[0]);
          chk("wr_ready_low", o_byteReady, 0);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
      end
      chk("hold_vs_done", o_cpuHold, !o_done);
      if (o_error) chk("err_ready_low", o_byteReady, 0);
      if (o_done) chk("done_ready_low", o_byteReady, 0);
    end
  end

  initial begin
    int got;
    @(negedge i_clock);
    do_reset();
    armed = 1'b1;

    // Two words back to back.
    stim = '{8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h03, 8'hFF, 8'hFF};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    build_model();
    chk("pin_a0", exp_addr[0], 0);
    chk("pin_d0", exp_data[0], 32'h01234);
    chk("pin_a1", exp_addr[1], 1);
    chk("pin_d1", exp_data[1], 32'h3FFFF);
    run("two_words", 1'b0);

    // Empty program.
    do_reset();
    stim = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    build_model();
    send(stim.size(), 1'b0, got);
    @(negedge i_clock);
    chk("empty_done_timing", o_done, 1);
    finish_checks("empty", got);

    // Malformed first B0.
    do_reset();
    stim = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h00};
    run("bad_b0", 1'b0);
    i_byte = 8'h00;
    i_byteValid = 1'b1;
    repeat (4) @(negedge i_clock);
    i_byteValid = 1'b0;
    chk("bad_b0_ready_after", o_byteReady, 0);
    chk("bad_b0_error_after", o_error, 1);
    chk("bad_b0_count_after", o_count, 0);

    // Three words with a random valid pattern.
    do_reset();
    stim = '{8'h00, 8'h03, 8'h01, 8'hAB, 8'hCD, 8'h02, 8'h00, 8'hFF,
             8'h00, 8'h55, 8'hAA};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    build_model();
    chk("pin_r0", exp_data[0], 32'h1ABCD);
    chk("pin_r1", exp_data[1], 32'h200FF);
    chk("pin_r2", exp_data[2], 32'h055AA);
    run("random_valid", 1'b1);

    // Reset in the cycle after the second word's B1.
    do_reset();
    stim = '{8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h01, 8'h33, 8'h44,
             8'h02, 8'h55, 8'h66, 8'h03, 8'h77, 8'h88};
    build_model();
    send(7, 1'b0, got);
    chk("midrst_consumed", got, 7);
    chk("midrst_pre_count", o_count, 1);
    chk("midrst_pending", exp_addr.size(), 3);
    do_reset();
    exp_addr.delete(); exp_data.delete();
    repeat (3) @(negedge i_clock);
    chk("midrst_idle_count", o_count, 0);
    stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h07};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    build_model();
    chk("pin_fresh", exp_data[0], 32'h00007);
    run("fresh", 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum byte: matching then mismatching.
    do_reset();
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
    build_model();
    chk("pin_csum_ok", exp_done, 1);
    run("csum_ok", 1'b0);
    do_reset();
    stim = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
    build_model();
    chk("pin_csum_bad", exp_err, 1);
    run("csum_bad", 1'b0);
`endif

    repeat (2) @(negedge i_clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
